// File: rtl/svc_rv_mem_arb.sv
// Arbiter sharing one single-ported memory between the svc_rv fetch (imem) and data (dmem) ports.
// Dmem wins by default; a saturating starve counter forces an imem grant after MAX_STARVE waits.
module svc_rv_mem_arb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_TYPE   = 0,
  parameter int MAX_STARVE = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  input  logic            i_flush,
  output logic            i_rsp_valid,
  output logic [DW-1:0]   i_rsp_data,

  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic            d_req_we,
  input  logic [AW-1:0]   d_req_addr,
  input  logic [DW-1:0]   d_req_wdata,
  input  logic [DW/8-1:0] d_req_wstrb,
  output logic            d_rsp_valid,
  output logic [DW-1:0]   d_rsp_data,

  output logic            mem_ren,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t     state;
  logic [3:0] starve;
  logic       run;
  logic       force_i;
  logic       grant_i;
  logic       grant_d;

  assign run = (state == ST_RUN);

  // Dmem has priority unless imem has already waited its full budget.
  assign force_i = run && i_req_valid && (starve == STARVE_LIMIT);
  assign grant_d = run && d_req_valid && !force_i;
  assign grant_i = run && i_req_valid && !grant_d;

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    mem_ren   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (grant_d) begin
      mem_addr  = d_req_addr;
      mem_we    = d_req_we;
      mem_ren   = !d_req_we;
      mem_wdata = d_req_wdata;
      mem_wstrb = d_req_wstrb;
    end else if (grant_i) begin
      mem_addr  = i_req_addr;
      mem_ren   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      starve <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= ST_RUN;
      if (run) begin
        if (grant_i || !i_req_valid) begin
          starve <= '0;
        end else if (starve != STARVE_LIMIT) begin
          starve <= starve + 4'd1;
        end
      end
    end
  end

  if (MEM_TYPE == 1) begin : g_bram
    logic pend_i;
    logic pend_d;

    // A new fetch granted alongside i_flush is the redirect target, so it is kept.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_i <= 1'b0;
        pend_d <= 1'b0;
      end else begin
        pend_i <= grant_i;
        pend_d <= grant_d && !d_req_we;
      end
    end

    assign i_rsp_valid = pend_i && !i_flush;
    assign d_rsp_valid = pend_d;
  end else begin : g_sram
    assign i_rsp_valid = grant_i && !i_flush;
    assign d_rsp_valid = grant_d && !d_req_we;
  end

  // Data is zeroed when not valid so idle and reset outputs are clean.
  assign i_rsp_data = i_rsp_valid ? mem_rdata : '0;
  assign d_rsp_data = d_rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// Self-checking bench: one SRAM-timed and one BRAM-timed arbiter share stimulus and are
// compared every cycle against a transaction-level model, plus directed literal checks.
module tb_svc_rv_mem_arb;

  localparam int MAX_STARVE = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_flush;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;

  // Index 0 = SRAM instance, index 1 = BRAM instance.
  logic        i_req_ready [2];
  logic        i_rsp_valid [2];
  logic [31:0] i_rsp_data  [2];
  logic        d_req_ready [2];
  logic        d_rsp_valid [2];
  logic [31:0] d_rsp_data  [2];
  logic        mem_ren     [2];
  logic        mem_we      [2];
  logic [31:0] mem_addr    [2];
  logic [31:0] mem_wdata   [2];
  logic [3:0]  mem_wstrb   [2];
  logic [31:0] sram_rdata;
  logic [31:0] bram_rdata;

  logic [31:0] mem_s   [64];
  logic [31:0] mem_b   [64];
  logic [31:0] ref_mem [64];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  svc_rv_mem_arb #(.AW(32), .DW(32), .MEM_TYPE(0), .MAX_STARVE(MAX_STARVE)) u_sram (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready[0]), .i_req_addr(i_req_addr),
    .i_flush(i_flush), .i_rsp_valid(i_rsp_valid[0]), .i_rsp_data(i_rsp_data[0]),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready[0]), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid[0]), .d_rsp_data(d_rsp_data[0]),
    .mem_ren(mem_ren[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_rdata(sram_rdata)
  );

  svc_rv_mem_arb #(.AW(32), .DW(32), .MEM_TYPE(1), .MAX_STARVE(MAX_STARVE)) u_bram (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready[1]), .i_req_addr(i_req_addr),
    .i_flush(i_flush), .i_rsp_valid(i_rsp_valid[1]), .i_rsp_data(i_rsp_data[1]),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready[1]), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid[1]), .d_rsp_data(d_rsp_data[1]),
    .mem_ren(mem_ren[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_rdata(bram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'h0000_0013;
    if (i == 25) return 32'hCAFE_0019;
    return 32'h1000_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory environment for both instances: SRAM reads combinationally, BRAM one edge later.
  assign sram_rdata = mem_s[mem_addr[0][7:2]];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_s[i] = init_word(i);
      mem_b[i] = init_word(i);
    end
    bram_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_we[0]) mem_s[mem_addr[0][7:2]] <= merge(mem_s[mem_addr[0][7:2]], mem_wdata[0], mem_wstrb[0]);
      if (mem_we[1]) mem_b[mem_addr[1][7:2]] <= merge(mem_b[mem_addr[1][7:2]], mem_wdata[1], mem_wstrb[1]);
      if (mem_ren[1]) bram_rdata <= mem_b[mem_addr[1][7:2]];
    end
  end

  // Reference model and per-cycle compare, evaluated on the falling edge.
  initial begin
    bit          run;
    int          wait_cnt;
    bit          gi, gd;
    bit          pend_i, pend_d;
    logic [31:0] pend_i_data, pend_d_data;
    logic [31:0] exp_addr, i_word, d_word;
    run = 0; wait_cnt = 0; pend_i = 0; pend_d = 0;
    pend_i_data = '0; pend_d_data = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("rst_i_ready%0d", k), i_req_ready[k], 1'b0);
          check($sformatf("rst_d_ready%0d", k), d_req_ready[k], 1'b0);
          check($sformatf("rst_i_rsp%0d", k), i_rsp_valid[k], 1'b0);
          check($sformatf("rst_d_rsp%0d", k), d_rsp_valid[k], 1'b0);
          check($sformatf("rst_ren%0d", k), mem_ren[k], 1'b0);
          check($sformatf("rst_we%0d", k), mem_we[k], 1'b0);
        end
        run = 0; wait_cnt = 0; pend_i = 0; pend_d = 0;
      end else begin
        gi = 0; gd = 0;
        if (run) begin
          if (i_req_valid && wait_cnt == MAX_STARVE) gi = 1;
          else if (d_req_valid) gd = 1;
          else if (i_req_valid) gi = 1;
        end
        exp_addr = gd ? d_req_addr : (gi ? i_req_addr : 32'h0);
        i_word   = ref_mem[i_req_addr[7:2]];
        d_word   = ref_mem[d_req_addr[7:2]];
        for (int k = 0; k < 2; k++) begin
          check($sformatf("i_ready%0d", k), i_req_ready[k], gi);
          check($sformatf("d_ready%0d", k), d_req_ready[k], gd);
          check($sformatf("mem_ren%0d", k), mem_ren[k], gi || (gd && !d_req_we));
          check($sformatf("mem_we%0d", k), mem_we[k], gd && d_req_we);
          check($sformatf("mem_addr%0d", k), mem_addr[k], exp_addr);
          check($sformatf("mem_wstrb%0d", k), mem_wstrb[k], gd ? d_req_wstrb : 4'h0);
          if (gd) check($sformatf("mem_wdata%0d", k), mem_wdata[k], d_req_wdata);
        end
        check("s_i_rsp_valid", i_rsp_valid[0], gi && !i_flush);
        if (gi && !i_flush) check("s_i_rsp_data", i_rsp_data[0], i_word);
        check("s_d_rsp_valid", d_rsp_valid[0], gd && !d_req_we);
        if (gd && !d_req_we) check("s_d_rsp_data", d_rsp_data[0], d_word);
        check("b_i_rsp_valid", i_rsp_valid[1], pend_i && !i_flush);
        if (pend_i && !i_flush) check("b_i_rsp_data", i_rsp_data[1], pend_i_data);
        check("b_d_rsp_valid", d_rsp_valid[1], pend_d);
        if (pend_d) check("b_d_rsp_data", d_rsp_data[1], pend_d_data);
        // Advance the model to the state after the coming rising edge.
        pend_i = gi;
        pend_i_data = i_word;
        pend_d = gd && !d_req_we;
        pend_d_data = d_word;
        if (gd && d_req_we) ref_mem[d_req_addr[7:2]] = merge(d_word, d_req_wdata, d_req_wstrb);
        if (run) wait_cnt = (i_req_valid && !gi) ? ((wait_cnt < MAX_STARVE) ? wait_cnt + 1 : wait_cnt) : 0;
        run = 1;
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] ia, input logic fl, input logic dv,
                       input logic we, input logic [31:0] da, input logic [31:0] wd,
                       input logic [3:0] ws);
    @(posedge clk);
    #1;
    i_req_valid = iv; i_req_addr = ia; i_flush = fl;
    d_req_valid = dv; d_req_we = we; d_req_addr = da; d_req_wdata = wd; d_req_wstrb = ws;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic [9:0]  gpat;
    logic [31:0] ra, rd, rw;
    rst_n = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h8; i_flush = 1'b0;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'hC;
    d_req_wdata = '0; d_req_wstrb = '0;

    // Reset release: readys low in reset and in the init cycle, grant after that.
    repeat (2) @(negedge clk);
    check("lit_rst_d_ready", d_req_ready[0], 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("lit_init_d_ready", d_req_ready[0], 1'b0);
    check("lit_init_i_ready", i_req_ready[0], 1'b0);
    @(negedge clk);
    check("lit_first_grant", d_req_ready[0], 1'b1);
    idle();
    idle();

    // Imem only, BRAM timing.
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("lit_b_ren", mem_ren[1], 1'b1);
    check("lit_b_addr", mem_addr[1], 32'h10);
    idle();
    @(negedge clk);
    check("lit_b_i_rsp_valid", i_rsp_valid[1], 1'b1);
    check("lit_b_i_rsp_data", i_rsp_data[1], 32'h13);

    // Simultaneous reads, SRAM timing.
    drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h64, 32'h0, 4'h0);
    @(negedge clk);
    check("lit_s_d_ready", d_req_ready[0], 1'b1);
    check("lit_s_i_blocked", i_req_ready[0], 1'b0);
    check("lit_s_d_rsp_data", d_rsp_data[0], 32'hCAFE0019);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("lit_s_i_next", i_req_ready[0], 1'b1);
    idle();

    // Starvation: grants go D D D D I D D D D I.
    gpat = '0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
      @(negedge clk);
      gpat[c] = i_req_ready[0];
    end
    check("lit_starve_pattern", gpat, 10'h210);
    idle();

    // Dmem partial write.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h50, 32'hDEADBEEF, 4'h3);
    @(negedge clk);
    check("lit_w_we", mem_we[0], 1'b1);
    check("lit_w_ren", mem_ren[0], 1'b0);
    check("lit_w_strb", mem_wstrb[0], 4'h3);
    check("lit_w_data", mem_wdata[0], 32'hDEADBEEF);
    idle();
    @(negedge clk);
    check("lit_w_no_rsp", d_rsp_valid[1], 1'b0);

    // BRAM flush with redirect fetch in the flush cycle.
    drive(1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 32'h64, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("lit_flush_kill", i_rsp_valid[1], 1'b0);
    idle();
    @(negedge clk);
    check("lit_redirect_valid", i_rsp_valid[1], 1'b1);
    check("lit_redirect_data", i_rsp_data[1], 32'hCAFE0019);

    // Async reset with a BRAM fetch in flight drops its response.
    drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("lit_rst_drop", i_rsp_valid[1], 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic with one mid-run reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      ra = 32'($urandom_range(0, 63)) << 2;
      rd = 32'($urandom_range(0, 63)) << 2;
      rw = $urandom;
      drive($urandom_range(0, 3) != 0, ra, $urandom_range(0, 6) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, rd, rw,
            4'($urandom_range(0, 15)));
    end
    idle();
    idle();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
